cordic_iter_ctrl: RTL and testbench

Sequencing controller for the iterative CORDIC datapath in the floating-to-fixed linearizer/normalizer. It accepts a start request and latches the operating mode. It then steps the shared add/sub datapath through ITER micro-rotations, deriving each iteration's direction and the three add/sub selects from the current sign bits. It holds the result until it is acknowledged. The controller owns the iteration counter and all load strobes; the datapath owns x/y/z storage and the shifters.

---
 rtl/cordic_iter_ctrl_pkg.sv | 20 ++
 rtl/cordic_iter_ctrl_if.sv | 35 +++
 rtl/xor_tri_L.sv | 12 +
 rtl/cordic_iter_ctrl.sv | 90 +++++++++
 tb/tb_cordic_iter_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_iter_ctrl_pkg.sv
// Shared types and constants for the CORDIC iteration controller.
// Covers the state encoding, the mode codes and the add/sub polarity.
package cordic_iter_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CALC   = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic ROT = 1'b0;
    localparam logic VEC = 1'b1;

    // Polarity bit fed to the op-select xor: SUB inverts the sign-derived select.
    localparam logic SUB = 1'b1;
    localparam logic ADD = 1'b0;

endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// Control bundle between the CORDIC datapath side and the iteration controller.
// Handshake: beg_fsm_i is taken only in IDLE; ready_o holds in DONE until ack_i is seen high on a rising edge.
interface cordic_iter_ctrl_if
    import cordic_iter_ctrl_pkg::*;
#(
    parameter int CW = 4
);
    logic          beg_fsm_i;
    logic          ack_i;
    logic          mode_i;
    logic          z_sign_i;
    logic          y_sign_i;
    logic          load_init_o;
    logic          load_regs_o;
    logic [CW-1:0] iter_o;
    logic          op_x_o;
    logic          op_y_o;
    logic          op_z_o;
    logic          busy_o;
    logic          ready_o;
    state_t        state_o;

    modport master (
        output beg_fsm_i, ack_i, mode_i, z_sign_i, y_sign_i,
        input  load_init_o, load_regs_o, iter_o, op_x_o, op_y_o, op_z_o,
               busy_o, ready_o, state_o
    );

    modport slave (
        input  beg_fsm_i, ack_i, mode_i, z_sign_i, y_sign_i,
        output load_init_o, load_regs_o, iter_o, op_x_o, op_y_o, op_z_o,
               busy_o, ready_o, state_o
    );

endinterface

// File: rtl/xor_tri_L.sv
// Three-input xor producing one add/sub select from the direction sign,
// the latched mode and a fixed polarity bit.
module xor_tri_L (
    input  logic sel,
    input  logic mode,
    input  logic pol,
    output logic op
);

    assign op = sel ^ mode ^ pol;

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Sequencer for the shared CORDIC add/sub datapath: load, ITER CALC/UPDATE pairs,
// then hold the result until acknowledged. Owns the iteration counter and load strobes.
module cordic_iter_ctrl
    import cordic_iter_ctrl_pkg::*;
#(
    parameter int ITER = 16,
    parameter int CW   = $clog2(ITER)
) (
    input logic               clk,
    input logic               rst_n,
    cordic_iter_ctrl_if.slave bus
);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          mode_q;
    logic          op_x_q;
    logic          op_y_q;
    logic          op_z_q;
    logic          sel;
    logic          op_x_d;
    logic          op_y_d;
    logic          op_z_d;
    logic          last_iter;

    // Rotation steers on z, vectoring steers on y.
    assign sel       = (mode_q == VEC) ? bus.y_sign_i : bus.z_sign_i;
    assign last_iter = (cnt_q == CW'(ITER - 1));

    xor_tri_L u_op_x (.sel(sel), .mode(mode_q), .pol(SUB), .op(op_x_d));
    xor_tri_L u_op_y (.sel(sel), .mode(mode_q), .pol(ADD), .op(op_y_d));
    xor_tri_L u_op_z (.sel(sel), .mode(mode_q), .pol(SUB), .op(op_z_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.beg_fsm_i) state_d = LOAD;
            LOAD:    state_d = CALC;
            CALC:    state_d = UPDATE;
            UPDATE:  state_d = last_iter ? DONE : CALC;
            DONE:    if (bus.ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            mode_q <= ROT;
            op_x_q <= 1'b0;
            op_y_q <= 1'b0;
            op_z_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.beg_fsm_i) begin
                mode_q <= bus.mode_i;
            end
            // Terminal compare stops the count at ITER-1, so it never wraps.
            if (state_q == LOAD) begin
                cnt_q <= '0;
            end else if (state_q == UPDATE && !last_iter) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == CALC) begin
                op_x_q <= op_x_d;
                op_y_q <= op_y_d;
                op_z_q <= op_z_d;
            end
        end
    end

    assign bus.load_init_o = (state_q == LOAD);
    assign bus.load_regs_o = (state_q == UPDATE);
    assign bus.busy_o      = (state_q == LOAD) || (state_q == CALC) || (state_q == UPDATE);
    assign bus.ready_o     = (state_q == DONE);
    assign bus.iter_o      = cnt_q;
    assign bus.op_x_o      = op_x_q;
    assign bus.op_y_o      = op_y_q;
    assign bus.op_z_o      = op_z_q;
    assign bus.state_o     = state_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: a 16-iteration instance for the main scenarios
// and a 2-iteration instance for the parameter edge.
module tb_cordic_iter_ctrl;
    import cordic_iter_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    cordic_iter_ctrl_if #(.CW(4)) a_if ();
    cordic_iter_ctrl_if #(.CW(1)) b_if ();

    cordic_iter_ctrl #(.ITER(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    cordic_iter_ctrl #(.ITER(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    // Per-cycle record of dut_a outputs; cycle 1 is the cycle after the start edge.
    logic       obs_li   [0:80];
    logic       obs_lr   [0:80];
    logic       obs_rdy  [0:80];
    logic       obs_busy [0:80];
    logic       obs_ox   [0:80];
    logic       obs_oy   [0:80];
    logic       obs_oz   [0:80];
    logic [3:0] obs_iter [0:80];
    state_t     obs_st   [0:80];
    int         ready_cyc;
    int         pulse_cnt;
    int         last_cyc;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "watchdog");
    end

    task automatic sample(input int c);
        obs_li[c]   = a_if.load_init_o;
        obs_lr[c]   = a_if.load_regs_o;
        obs_rdy[c]  = a_if.ready_o;
        obs_busy[c] = a_if.busy_o;
        obs_ox[c]   = a_if.op_x_o;
        obs_oy[c]   = a_if.op_y_o;
        obs_oz[c]   = a_if.op_z_o;
        obs_iter[c] = a_if.iter_o;
        obs_st[c]   = a_if.state_o;
    endtask

    // Drives one transaction on dut_a and records outputs; no checking here.
    task automatic run_a(input logic m, input logic [15:0] pat, input bit other_inv,
                         input int ack_delay, input bit poke_busy, input bit beg_with_ack);
        int ack_at;
        ack_at    = -1;
        ready_cyc = -1;
        pulse_cnt = 0;
        last_cyc  = 0;
        for (int i = 0; i <= 80; i++) begin
            obs_li[i] = 0; obs_lr[i] = 0; obs_rdy[i] = 0; obs_busy[i] = 0;
            obs_ox[i] = 0; obs_oy[i] = 0; obs_oz[i] = 0; obs_iter[i] = 0; obs_st[i] = IDLE;
        end
        a_if.mode_i    = m;
        a_if.ack_i     = 1'b0;
        a_if.beg_fsm_i = 1'b1;
        @(posedge clk); #1;
        a_if.beg_fsm_i = 1'b0;
        for (int c = 1; c < 80; c++) begin
            if (c >= 2 && c <= 32 && (c % 2) == 0) begin
                if (m == VEC) begin
                    a_if.y_sign_i = pat[(c-2)/2];
                    a_if.z_sign_i = pat[(c-2)/2] ^ other_inv;
                end else begin
                    a_if.z_sign_i = pat[(c-2)/2];
                    a_if.y_sign_i = pat[(c-2)/2] ^ other_inv;
                end
            end
            if (poke_busy) begin
                a_if.beg_fsm_i = (c == 5 || c == 20);
                if (c >= 5) a_if.mode_i = ~m;
                a_if.ack_i = (c == 10);
            end
            sample(c);
            if (obs_lr[c]) pulse_cnt++;
            if (obs_rdy[c] && ready_cyc < 0) begin
                ready_cyc = c;
                ack_at    = c + ack_delay;
            end
            if (c == ack_at) begin
                a_if.ack_i = 1'b1;
                if (beg_with_ack) a_if.beg_fsm_i = 1'b1;
            end
            @(posedge clk); #1;
            a_if.ack_i = 1'b0;
            if (c == ack_at) begin
                sample(c + 1);
                last_cyc = c + 1;
                break;
            end
        end
        a_if.mode_i = m;
    endtask

    task automatic test_reset_values();
        n_checks++;
        if ({a_if.load_init_o, a_if.load_regs_o, a_if.iter_o, a_if.op_x_o, a_if.op_y_o,
             a_if.op_z_o, a_if.busy_o, a_if.ready_o} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_a: got %0h expected 0", {a_if.load_init_o, a_if.load_regs_o,
                     a_if.iter_o, a_if.op_x_o, a_if.op_y_o, a_if.op_z_o, a_if.busy_o, a_if.ready_o});
        end
        n_checks++;
        if (a_if.state_o !== IDLE || b_if.state_o !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d/%0d expected IDLE", a_if.state_o, b_if.state_o);
        end
        n_checks++;
        if ({b_if.load_init_o, b_if.load_regs_o, b_if.iter_o, b_if.busy_o, b_if.ready_o} !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_b: got %0h expected 0",
                     {b_if.load_init_o, b_if.load_regs_o, b_if.iter_o, b_if.busy_o, b_if.ready_o});
        end
    endtask

    task automatic test_rotation();
        run_a(ROT, 16'h0000, 1'b1, 0, 1'b0, 1'b0);
        n_checks++;
        if (ready_cyc !== 34) begin n_fail++; $display("FAIL rot_ready_cycle: got %0d expected 34", ready_cyc); end
        n_checks++;
        if (pulse_cnt !== 16) begin n_fail++; $display("FAIL rot_pulses: got %0d expected 16", pulse_cnt); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({obs_lr[3+2*k], obs_iter[2+2*k], obs_iter[3+2*k], obs_ox[3+2*k], obs_oy[3+2*k], obs_oz[3+2*k]}
                !== {1'b1, 4'(k), 4'(k), 3'b101}) begin
                n_fail++;
                $display("FAIL rot_iter%0d: got lr=%0b iter=%0d/%0d op=%0b%0b%0b expected lr=1 iter=%0d op=101",
                         k, obs_lr[3+2*k], obs_iter[2+2*k], obs_iter[3+2*k],
                         obs_ox[3+2*k], obs_oy[3+2*k], obs_oz[3+2*k], k);
            end
        end
        for (int c = 1; c <= 34; c++) begin
            n_checks++;
            if (obs_busy[c] !== (c <= 33)) begin
                n_fail++;
                $display("FAIL rot_busy_c%0d: got %0b expected %0b", c, obs_busy[c], (c <= 33));
            end
        end
        n_checks++;
        if ({obs_li[1], obs_li[2], obs_lr[2]} !== 3'b100) begin
            n_fail++;
            $display("FAIL rot_load_init: got %0b%0b%0b expected 100", obs_li[1], obs_li[2], obs_lr[2]);
        end
        n_checks++;
        if (obs_st[last_cyc] !== IDLE || obs_rdy[last_cyc] !== 1'b0) begin
            n_fail++;
            $display("FAIL rot_after_ack: got state %0d ready %0b expected IDLE 0", obs_st[last_cyc], obs_rdy[last_cyc]);
        end
    endtask

    task automatic test_pattern_rot();
        logic [15:0] pat;
        pat = 16'hA5C3;
        run_a(ROT, pat, 1'b1, 0, 1'b0, 1'b0);
        n_checks++;
        if (ready_cyc !== 34) begin n_fail++; $display("FAIL patrot_ready_cycle: got %0d expected 34", ready_cyc); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({obs_ox[3+2*k], obs_oy[3+2*k], obs_oz[3+2*k]} !== {~pat[k], pat[k], ~pat[k]}) begin
                n_fail++;
                $display("FAIL patrot_op%0d: got %0b%0b%0b expected %0b%0b%0b", k, obs_ox[3+2*k],
                         obs_oy[3+2*k], obs_oz[3+2*k], ~pat[k], pat[k], ~pat[k]);
            end
        end
    endtask

    task automatic test_vectoring();
        logic [15:0] pat;
        pat = 16'h5555;
        run_a(VEC, pat, 1'b1, 0, 1'b0, 1'b0);
        n_checks++;
        if (ready_cyc !== 34) begin n_fail++; $display("FAIL vec_ready_cycle: got %0d expected 34", ready_cyc); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({obs_ox[3+2*k], obs_oy[3+2*k], obs_oz[3+2*k]} !== {pat[k], ~pat[k], pat[k]}) begin
                n_fail++;
                $display("FAIL vec_op%0d: got %0b%0b%0b expected %0b%0b%0b", k, obs_ox[3+2*k],
                         obs_oy[3+2*k], obs_oz[3+2*k], pat[k], ~pat[k], pat[k]);
            end
            if (k > 0) begin
                n_checks++;
                if (obs_oy[2+2*k] !== ~pat[k-1]) begin
                    n_fail++;
                    $display("FAIL vec_hold%0d: got op_y %0b in CALC expected %0b", k, obs_oy[2+2*k], ~pat[k-1]);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int li_cnt;
        run_a(ROT, 16'h0000, 1'b0, 0, 1'b1, 1'b0);
        li_cnt = 0;
        for (int c = 1; c <= 80; c++) if (obs_li[c]) li_cnt++;
        n_checks++;
        if (pulse_cnt !== 16) begin n_fail++; $display("FAIL busy_pulses: got %0d expected 16", pulse_cnt); end
        n_checks++;
        if (li_cnt !== 1) begin n_fail++; $display("FAIL busy_load_init_count: got %0d expected 1", li_cnt); end
        n_checks++;
        if (ready_cyc !== 34) begin n_fail++; $display("FAIL busy_ready_cycle: got %0d expected 34", ready_cyc); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({obs_ox[3+2*k], obs_oy[3+2*k], obs_oz[3+2*k]} !== 3'b101) begin
                n_fail++;
                $display("FAIL busy_mode_op%0d: got %0b%0b%0b expected 101", k,
                         obs_ox[3+2*k], obs_oy[3+2*k], obs_oz[3+2*k]);
            end
        end
    endtask

    task automatic test_held_result();
        bit got;
        run_a(VEC, 16'h00FF, 1'b1, 10, 1'b0, 1'b1);
        n_checks++;
        if (ready_cyc !== 34) begin n_fail++; $display("FAIL held_ready_cycle: got %0d expected 34", ready_cyc); end
        for (int c = 34; c <= 44; c++) begin
            n_checks++;
            if ({obs_rdy[c], obs_ox[c], obs_oy[c], obs_oz[c]} !== 4'b1010) begin
                n_fail++;
                $display("FAIL held_c%0d: got ready=%0b op=%0b%0b%0b expected ready=1 op=010", c,
                         obs_rdy[c], obs_ox[c], obs_oy[c], obs_oz[c]);
            end
        end
        n_checks++;
        if ({obs_st[45], obs_rdy[45], obs_li[45]} !== {IDLE, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL held_ack_beg: got state %0d ready %0b load_init %0b expected IDLE 0 0",
                     obs_st[45], obs_rdy[45], obs_li[45]);
        end
        // beg_fsm_i is still held, so the start is taken on this IDLE cycle.
        @(posedge clk); #1;
        a_if.beg_fsm_i = 1'b0;
        n_checks++;
        if (a_if.load_init_o !== 1'b1 || a_if.state_o !== LOAD) begin
            n_fail++;
            $display("FAIL held_restart: got load_init %0b state %0d expected 1 LOAD", a_if.load_init_o, a_if.state_o);
        end
        got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge clk); #1;
            if (a_if.ready_o) got = 1;
        end
        n_checks++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL held_drain: got ready %0b expected 1 within 60 cycles", got); end
        a_if.ack_i = 1'b1;
        @(posedge clk); #1;
        a_if.ack_i = 1'b0;
    endtask

    task automatic test_reset();
        a_if.mode_i    = ROT;
        a_if.z_sign_i  = 1'b0;
        a_if.y_sign_i  = 1'b0;
        a_if.beg_fsm_i = 1'b1;
        @(posedge clk); #1;
        a_if.beg_fsm_i = 1'b0;
        repeat (11) begin @(posedge clk); #1; end
        n_checks++;
        if (a_if.iter_o !== 4'd5) begin n_fail++; $display("FAIL rst_pre_iter: got %0d expected 5", a_if.iter_o); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_if.load_init_o, a_if.load_regs_o, a_if.iter_o, a_if.op_x_o, a_if.op_y_o,
             a_if.op_z_o, a_if.busy_o, a_if.ready_o, a_if.state_o} !== 14'h0) begin
            n_fail++;
            $display("FAIL rst_async: got %0h expected 0", {a_if.load_init_o, a_if.load_regs_o, a_if.iter_o,
                     a_if.op_x_o, a_if.op_y_o, a_if.op_z_o, a_if.busy_o, a_if.ready_o, a_if.state_o});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({a_if.load_init_o, a_if.load_regs_o, a_if.iter_o, a_if.op_x_o, a_if.op_y_o,
             a_if.op_z_o, a_if.busy_o, a_if.ready_o, a_if.state_o} !== 14'h0) begin
            n_fail++;
            $display("FAIL rst_after_release: got %0h expected 0", {a_if.load_init_o, a_if.load_regs_o,
                     a_if.iter_o, a_if.op_x_o, a_if.op_y_o, a_if.op_z_o, a_if.busy_o, a_if.ready_o, a_if.state_o});
        end
        run_a(ROT, 16'h0000, 1'b1, 0, 1'b0, 1'b0);
        n_checks++;
        if (ready_cyc !== 34) begin n_fail++; $display("FAIL rst_restart_ready: got %0d expected 34", ready_cyc); end
        n_checks++;
        if (pulse_cnt !== 16) begin n_fail++; $display("FAIL rst_restart_pulses: got %0d expected 16", pulse_cnt); end
    endtask

    task automatic test_iter2();
        int rdy_c;
        int pulses;
        b_if.mode_i    = ROT;
        b_if.z_sign_i  = 1'b1;
        b_if.y_sign_i  = 1'b0;
        b_if.beg_fsm_i = 1'b1;
        @(posedge clk); #1;
        b_if.beg_fsm_i = 1'b0;
        rdy_c  = -1;
        pulses = 0;
        for (int c = 1; c < 20 && rdy_c < 0; c++) begin
            if (b_if.load_regs_o) pulses++;
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (b_if.iter_o !== 1'((c - 2) / 2)) begin
                    n_fail++;
                    $display("FAIL iter2_index_c%0d: got %0d expected %0d", c, b_if.iter_o, (c - 2) / 2);
                end
            end
            if (c == 3 || c == 5) begin
                n_checks++;
                if ({b_if.load_regs_o, b_if.op_x_o, b_if.op_y_o, b_if.op_z_o} !== 4'b1010) begin
                    n_fail++;
                    $display("FAIL iter2_update_c%0d: got lr=%0b op=%0b%0b%0b expected lr=1 op=010", c,
                             b_if.load_regs_o, b_if.op_x_o, b_if.op_y_o, b_if.op_z_o);
                end
            end
            if (b_if.ready_o) rdy_c = c;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (rdy_c !== 6) begin n_fail++; $display("FAIL iter2_ready_cycle: got %0d expected 6", rdy_c); end
        n_checks++;
        if (pulses !== 2) begin n_fail++; $display("FAIL iter2_pulses: got %0d expected 2", pulses); end
        b_if.ack_i = 1'b1;
        @(posedge clk); #1;
        b_if.ack_i = 1'b0;
        n_checks++;
        if (b_if.state_o !== IDLE || b_if.ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL iter2_after_ack: got state %0d ready %0b expected IDLE 0", b_if.state_o, b_if.ready_o);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        a_if.beg_fsm_i = 1'b0; a_if.ack_i = 1'b0; a_if.mode_i = 1'b0;
        a_if.z_sign_i  = 1'b0; a_if.y_sign_i = 1'b0;
        b_if.beg_fsm_i = 1'b0; b_if.ack_i = 1'b0; b_if.mode_i = 1'b0;
        b_if.z_sign_i  = 1'b0; b_if.y_sign_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset_values();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_rotation();
        test_pattern_rot();
        test_vectoring();
        test_start_while_busy();
        test_held_result();
        test_reset();
        test_iter2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
